// File: rtl/assign_op_regfile.sv
// assign_op_regfile: register array applying assignment operators per transaction; `<<=`/`>>=` legal only with ASSIGN_OP_REGFILE_SHIFT_EN
module assign_op_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [IDXW-1:0]  in_idx,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [WIDTH-1:0] out_old,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_err
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [WIDTH-1:0] out_value_q, out_value_d, out_old_q, out_old_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic accept, hit, op_ok;
  logic [WIDTH-1:0] cur, sh, res, val;
  assign in_ready = !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_old = out_old_q;
  assign out_idx = out_idx_q;
  assign out_err = out_err_q;
  always_comb begin
    cur = '0;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (in_idx == IDXW'(i)) begin
        cur = mem_q[i];
        hit = 1'b1;
      end
`ifdef ASSIGN_OP_REGFILE_SHIFT_EN
    sh = (in_data >= WIDTH'(WIDTH)) ? '0 : in_op[0] ? cur >> in_data : cur << in_data;
    op_ok = 1'b1;
`else
    sh = '0;
    op_ok = in_op[2:1] != 2'b11;
`endif
    res = in_op == 3'd0 ? in_data :
          in_op == 3'd1 ? cur + in_data :
          in_op == 3'd2 ? cur - in_data :
          in_op == 3'd3 ? cur & in_data :
          in_op == 3'd4 ? cur | in_data :
          in_op == 3'd5 ? cur ^ in_data : sh;
    val = !hit ? '0 : op_ok ? res : cur;
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++)
      if (accept && hit && op_ok && in_idx == IDXW'(i)) mem_d[i] = res;
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_value_d = accept ? val : out_value_q;
    out_old_d = accept ? cur : out_old_q;
    out_err_d = accept ? !(hit && op_ok) : out_err_q;
    out_idx_d = accept ? in_idx : out_idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_old_q <= '0;
      out_idx_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_old_q <= out_old_d;
      out_idx_q <= out_idx_d;
      out_err_q <= out_err_d;
    end
  end
endmodule
